// File: rtl/axi_2_obi_pkg.sv
// rtl/axi_2_obi_pkg.sv - shared types and constants for the AXI4-to-OBI bridge
package axi_2_obi_pkg;

    localparam int AXI_IDW   = 4;
    localparam int AXI_ADDRW = 32;
    localparam int AXI_DATAW = 32;
    localparam int AXI_STRBW = AXI_DATAW / 8;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_RD_RESP,
        ST_WR_DATA,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_WR_RESP
    } state_e;

    typedef struct packed {
        logic [AXI_IDW-1:0]   id;
        logic [AXI_ADDRW-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
    } axi_ax_t;

    typedef struct packed {
        logic [AXI_DATAW-1:0] data;
        logic [AXI_STRBW-1:0] strb;
        logic                 last;
    } axi_w_t;

    typedef struct packed {
        logic [AXI_IDW-1:0] id;
        logic [1:0]         resp;
    } axi_b_t;

    typedef struct packed {
        logic [AXI_IDW-1:0]   id;
        logic [AXI_DATAW-1:0] data;
        logic [1:0]           resp;
        logic                 last;
    } axi_r_t;

    typedef struct packed {
        axi_ax_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_req_s;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        logic   b_valid;
        axi_b_t b;
        logic   r_valid;
        axi_r_t r;
    } axi_resp_s;

endpackage

// File: rtl/axi_2_obi_addr_gen.sv
// rtl/axi_2_obi_addr_gen.sv - next beat address for FIXED/INCR/WRAP bursts
module axi_2_obi_addr_gen
    import axi_2_obi_pkg::*;
#(
    parameter int ADDRW = 32,
    parameter int STRBW = 4
) (
    input  logic [ADDRW-1:0] addr,
    input  logic [2:0]       size,
    input  logic [7:0]       len,
    input  logic [1:0]       burst,
    output logic [ADDRW-1:0] next_addr
);

    // Beats wider than the bus are treated as full-width beats.
    localparam logic [2:0] MAX_SIZE = 3'($clog2(STRBW));

    logic [2:0]       eff_size;
    logic [ADDRW-1:0] step;
    logic [ADDRW-1:0] incr_addr;
    logic [ADDRW-1:0] wrap_bytes;
    logic [ADDRW-1:0] wrap_mask;
    logic             wrap_ok;

    // Compute the incremented address and, for legal wrap lengths, fold it into the wrap window.
    always_comb begin
        eff_size   = (size > MAX_SIZE) ? MAX_SIZE : size;
        step       = ADDRW'(1) << eff_size;
        incr_addr  = addr + step;
        wrap_bytes = (ADDRW'(len) + ADDRW'(1)) << eff_size;
        wrap_mask  = wrap_bytes - ADDRW'(1);
        wrap_ok    = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        next_addr  = incr_addr;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP: begin
                if (wrap_ok) begin
                    next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
                end
            end
            default: next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi_2_obi_core.sv
// rtl/axi_2_obi_core.sv - AXI4 subordinate to OBI manager bridge, one OBI transaction per beat
module axi_2_obi_core
    import axi_2_obi_pkg::*;
#(
    parameter int  OBI_ADDRW  = 32,
    parameter int  OBI_DATAW  = 32,
    parameter int  OBI_STRBW  = OBI_DATAW / 8,
    parameter type axi_req_t  = axi_req_s,
    parameter type axi_resp_t = axi_resp_s
) (
    input  logic                 clk_i,
    input  logic                 arst_ni,
    input  axi_req_t             axi_req_i,
    output axi_resp_t            axi_resp_o,
    output logic [OBI_ADDRW-1:0] addr_o,
    output logic                 we_o,
    output logic [OBI_DATAW-1:0] wdata_o,
    output logic [OBI_STRBW-1:0] be_o,
    output logic                 req_o,
    input  logic                 gnt_i,
    input  logic                 rvalid_i,
    input  logic [OBI_DATAW-1:0] rdata_i,
    input  logic                 err_i
);

    state_e               state_q;
    logic                 prio_q;      // 0: read wins a tie, 1: write wins a tie
    logic [AXI_IDW-1:0]   id_q;
    logic [OBI_ADDRW-1:0] addr_q;
    logic [7:0]           len_q;
    logic [2:0]           size_q;
    logic [1:0]           burst_q;
    logic [7:0]           beat_q;
    logic                 err_q;
    logic                 req_q;
    logic                 we_q;
    logic [OBI_STRBW-1:0] be_q;
    logic [OBI_DATAW-1:0] wdata_q;
    logic                 w_ready_q;
    logic                 r_valid_q;
    logic [OBI_DATAW-1:0] r_data_q;
    logic [1:0]           r_resp_q;
    logic                 r_last_q;
    logic                 b_valid_q;
    logic [1:0]           b_resp_q;

    logic                 idle;
    logic                 ar_sel;
    logic                 aw_sel;
    logic                 last_beat;
    logic [OBI_ADDRW-1:0] next_addr;
    axi_resp_s            resp;

    axi_2_obi_addr_gen #(
        .ADDRW (OBI_ADDRW),
        .STRBW (OBI_STRBW)
    ) u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    assign idle      = (state_q == ST_IDLE);
    assign last_beat = (beat_q == len_q);

    // Channel selection in IDLE: a lone valid wins, a tie goes to the priority bit.
    always_comb begin
        ar_sel = axi_req_i.ar_valid && (!axi_req_i.aw_valid || !prio_q);
        aw_sel = axi_req_i.aw_valid && (!axi_req_i.ar_valid ||  prio_q);
    end

    // Main bridge FSM; every OBI and AXI valid output comes from a register here.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q   <= ST_IDLE;
            prio_q    <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            beat_q    <= '0;
            err_q     <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
            w_ready_q <= 1'b0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_resp_q  <= RESP_OKAY;
            r_last_q  <= 1'b0;
            b_valid_q <= 1'b0;
            b_resp_q  <= RESP_OKAY;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ar_sel) begin
                        id_q    <= axi_req_i.ar.id;
                        addr_q  <= axi_req_i.ar.addr;
                        len_q   <= axi_req_i.ar.len;
                        size_q  <= axi_req_i.ar.size;
                        burst_q <= axi_req_i.ar.burst;
                        beat_q  <= '0;
                        err_q   <= 1'b0;
                        req_q   <= 1'b1;
                        we_q    <= 1'b0;
                        be_q    <= '1;
                        if (axi_req_i.aw_valid) prio_q <= ~prio_q;
                        state_q <= ST_RD_REQ;
                    end else if (aw_sel) begin
                        id_q      <= axi_req_i.aw.id;
                        addr_q    <= axi_req_i.aw.addr;
                        len_q     <= axi_req_i.aw.len;
                        size_q    <= axi_req_i.aw.size;
                        burst_q   <= axi_req_i.aw.burst;
                        beat_q    <= '0;
                        err_q     <= 1'b0;
                        w_ready_q <= 1'b1;
                        if (axi_req_i.ar_valid) prio_q <= ~prio_q;
                        state_q   <= ST_WR_DATA;
                    end
                end
                ST_RD_REQ: begin
                    if (gnt_i) begin
                        req_q   <= 1'b0;
                        state_q <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (rvalid_i) begin
                        r_data_q  <= rdata_i;
                        r_resp_q  <= err_i ? RESP_SLVERR : RESP_OKAY;
                        r_last_q  <= last_beat;
                        r_valid_q <= 1'b1;
                        state_q   <= ST_RD_RESP;
                    end
                end
                ST_RD_RESP: begin
                    if (axi_req_i.r_ready) begin
                        r_valid_q <= 1'b0;
                        if (r_last_q) begin
                            state_q <= ST_IDLE;
                        end else begin
                            beat_q  <= beat_q + 8'd1;
                            addr_q  <= next_addr;
                            req_q   <= 1'b1;
                            we_q    <= 1'b0;
                            be_q    <= '1;
                            state_q <= ST_RD_REQ;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (axi_req_i.w_valid) begin
                        wdata_q   <= axi_req_i.w.data;
                        be_q      <= axi_req_i.w.strb;
                        we_q      <= 1'b1;
                        req_q     <= 1'b1;
                        w_ready_q <= 1'b0;
                        if (axi_req_i.w.last != last_beat) err_q <= 1'b1;
                        state_q   <= ST_WR_REQ;
                    end
                end
                ST_WR_REQ: begin
                    if (gnt_i) begin
                        req_q   <= 1'b0;
                        state_q <= ST_WR_WAIT;
                    end
                end
                ST_WR_WAIT: begin
                    if (rvalid_i) begin
                        if (err_i) err_q <= 1'b1;
                        if (last_beat) begin
                            b_valid_q <= 1'b1;
                            b_resp_q  <= (err_q || err_i) ? RESP_SLVERR : RESP_OKAY;
                            state_q   <= ST_WR_RESP;
                        end else begin
                            beat_q    <= beat_q + 8'd1;
                            addr_q    <= next_addr;
                            w_ready_q <= 1'b1;
                            state_q   <= ST_WR_DATA;
                        end
                    end
                end
                ST_WR_RESP: begin
                    if (axi_req_i.b_ready) begin
                        b_valid_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Assemble the AXI response; address-channel readies are the only combinational outputs.
    always_comb begin
        resp          = '0;
        resp.ar_ready = idle && ar_sel;
        resp.aw_ready = idle && aw_sel;
        resp.w_ready  = w_ready_q;
        resp.b_valid  = b_valid_q;
        resp.b.id     = id_q;
        resp.b.resp   = b_resp_q;
        resp.r_valid  = r_valid_q;
        resp.r.id     = id_q;
        resp.r.data   = r_data_q;
        resp.r.resp   = r_resp_q;
        resp.r.last   = r_last_q;
    end

    assign axi_resp_o = resp;
    assign addr_o     = addr_q;
    assign we_o       = we_q;
    assign wdata_o    = wdata_q;
    assign be_o       = be_q;
    assign req_o      = req_q;

endmodule

// File: tb/tb_axi_2_obi_core.sv
// tb/tb_axi_2_obi_core.sv - directed scoreboard bench for the AXI4-to-OBI bridge
module tb_axi_2_obi_core;
    import axi_2_obi_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } oexp_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  id;
        logic [1:0]  resp;
        logic        last;
    } rexp_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    logic        clk_i = 1'b0;
    logic        arst_ni = 1'b0;
    axi_req_s    req;
    axi_resp_s   resp;
    logic [31:0] addr_o;
    logic        we_o;
    logic [31:0] wdata_o;
    logic [3:0]  be_o;
    logic        req_o;
    logic        gnt_i = 1'b0;
    logic        rvalid_i = 1'b0;
    logic [31:0] rdata_i = '0;
    logic        err_i = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int rv_cyc = 0;

    oexp_t obi_exp[$];
    rexp_t r_exp[$];
    bexp_t b_exp[$];

    axi_2_obi_core dut (
        .clk_i      (clk_i),
        .arst_ni    (arst_ni),
        .axi_req_i  (req),
        .axi_resp_o (resp),
        .addr_o     (addr_o),
        .we_o       (we_o),
        .wdata_o    (wdata_o),
        .be_o       (be_o),
        .req_o      (req_o),
        .gnt_i      (gnt_i),
        .rvalid_i   (rvalid_i),
        .rdata_i    (rdata_i),
        .err_i      (err_i)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        req.ar.id = id; req.ar.addr = addr; req.ar.len = len; req.ar.size = size; req.ar.burst = burst;
        req.ar_valid = 1'b1;
        #1;
        while (!resp.ar_ready && n < 50) begin tick(); #1; n++; end
        chk("ar_handshake", resp.ar_ready, 1);
        hs_cyc = cyc;
        tick();
        req.ar_valid = 1'b0;
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        req.aw.id = id; req.aw.addr = addr; req.aw.len = len; req.aw.size = size; req.aw.burst = burst;
        req.aw_valid = 1'b1;
        #1;
        while (!resp.aw_ready && n < 50) begin tick(); #1; n++; end
        chk("aw_handshake", resp.aw_ready, 1);
        hs_cyc = cyc;
        tick();
        req.aw_valid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        req.w.data = data; req.w.strb = strb; req.w.last = last;
        req.w_valid = 1'b1;
        #1;
        while (!resp.w_ready && n < 50) begin tick(); #1; n++; end
        chk("w_handshake", resp.w_ready, 1);
        tick();
        req.w_valid = 1'b0;
    endtask

    // Act as the OBI subordinate for one transaction, checking the request against the scoreboard.
    task automatic serve(input logic [31:0] rd, input logic e, input int gdly);
        oexp_t o;
        int n = 0;
        chk("obi_exp_pending", obi_exp.size() > 0, 1);
        if (obi_exp.size() == 0) return;
        o = obi_exp.pop_front();
        while (!req_o && n < 50) begin tick(); n++; end
        chk("obi_req", req_o, 1);
        chk("obi_addr", addr_o, o.addr);
        chk("obi_we", we_o, o.we);
        chk("obi_be", be_o, o.be);
        if (o.we) chk("obi_wdata", wdata_o, o.wdata);
        for (int i = 0; i < gdly; i++) begin
            tick();
            chk("stall_req", req_o, 1);
            chk("stall_addr", addr_o, o.addr);
            chk("stall_we", we_o, o.we);
            chk("stall_be", be_o, o.be);
        end
        gnt_i = 1'b1;
        tick();
        gnt_i = 1'b0;
        chk("req_after_gnt", req_o, 0);
        rvalid_i = 1'b1; rdata_i = rd; err_i = e;
        tick();
        rvalid_i = 1'b0; rdata_i = '0; err_i = 1'b0;
    endtask

    task automatic collect_r(input int stall);
        rexp_t x;
        int n = 0;
        while (!resp.r_valid && n < 50) begin tick(); n++; end
        chk("r_valid", resp.r_valid, 1);
        rv_cyc = cyc;
        for (int i = 0; i < stall; i++) begin
            chk("r_bp_no_req", req_o, 0);
            tick();
            chk("r_bp_held", resp.r_valid, 1);
        end
        chk("r_exp_pending", r_exp.size() > 0, 1);
        if (r_exp.size() == 0) return;
        x = r_exp.pop_front();
        chk("r_data", resp.r.data, x.data);
        chk("r_id", resp.r.id, x.id);
        chk("r_resp", resp.r.resp, x.resp);
        chk("r_last", resp.r.last, x.last);
        req.r_ready = 1'b1;
        tick();
        req.r_ready = 1'b0;
    endtask

    task automatic collect_b(input int stall);
        bexp_t x;
        int n = 0;
        while (!resp.b_valid && n < 50) begin tick(); n++; end
        chk("b_valid", resp.b_valid, 1);
        rv_cyc = cyc;
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("b_bp_held", resp.b_valid, 1);
        end
        chk("b_exp_pending", b_exp.size() > 0, 1);
        if (b_exp.size() == 0) return;
        x = b_exp.pop_front();
        chk("b_id", resp.b.id, x.id);
        chk("b_resp", resp.b.resp, x.resp);
        req.b_ready = 1'b1;
        tick();
        req.b_ready = 1'b0;
    endtask

    initial begin
        req = '0;
        repeat (3) tick();

        // Reset state
        chk("rst_req", req_o, 0);
        chk("rst_addr", addr_o, 0);
        chk("rst_we", we_o, 0);
        chk("rst_be", be_o, 0);
        chk("rst_wdata", wdata_o, 0);
        chk("rst_resp_zero", resp == '0, 1);
        arst_ni = 1'b1;
        tick();

        // Single read with latency check
        obi_exp.push_back('{32'h100, 1'b0, 4'hF, 32'h0});
        r_exp.push_back('{32'hDEADBEEF, 4'd3, RESP_OKAY, 1'b1});
        send_ar(4'd3, 32'h100, 8'd0, 3'd2, BURST_INCR);
        serve(32'hDEADBEEF, 1'b0, 0);
        collect_r(0);
        chk("rd_latency", rv_cyc - hs_cyc, 3);

        // INCR read burst with r_ready backpressure on beat 1
        for (int i = 0; i < 4; i++) begin
            obi_exp.push_back('{32'h200 + 32'(4 * i), 1'b0, 4'hF, 32'h0});
            r_exp.push_back('{32'hA000_0000 + 32'(i), 4'd2, RESP_OKAY, i == 3});
        end
        send_ar(4'd2, 32'h200, 8'd3, 3'd2, BURST_INCR);
        for (int i = 0; i < 4; i++) begin
            serve(32'hA000_0000 + 32'(i), 1'b0, 0);
            collect_r(i == 1 ? 5 : 0);
        end

        // Single write with latency check
        obi_exp.push_back('{32'h90, 1'b1, 4'hC, 32'hCAFE0000});
        b_exp.push_back('{4'd1, RESP_OKAY});
        send_aw(4'd1, 32'h90, 8'd0, 3'd2, BURST_INCR);
        send_w(32'hCAFE0000, 4'hC, 1'b1);
        serve(32'h0, 1'b0, 0);
        collect_b(0);
        chk("wr_latency", rv_cyc - hs_cyc, 4);

        // Two-beat write, error on the second OBI response
        obi_exp.push_back('{32'h40, 1'b1, 4'hF, 32'h1111_1111});
        obi_exp.push_back('{32'h44, 1'b1, 4'h3, 32'h2222_2222});
        b_exp.push_back('{4'd5, RESP_SLVERR});
        send_aw(4'd5, 32'h40, 8'd1, 3'd2, BURST_INCR);
        send_w(32'h1111_1111, 4'hF, 1'b0);
        serve(32'h0, 1'b0, 0);
        send_w(32'h2222_2222, 4'h3, 1'b1);
        serve(32'h0, 1'b1, 0);
        collect_b(2);

        // WRAP read with a 4-cycle grant stall on beat 0 and an error on beat 2
        obi_exp.push_back('{32'h38, 1'b0, 4'hF, 32'h0});
        obi_exp.push_back('{32'h3C, 1'b0, 4'hF, 32'h0});
        obi_exp.push_back('{32'h30, 1'b0, 4'hF, 32'h0});
        obi_exp.push_back('{32'h34, 1'b0, 4'hF, 32'h0});
        for (int i = 0; i < 4; i++)
            r_exp.push_back('{32'hB000_0000 + 32'(i), 4'd7, (i == 2) ? RESP_SLVERR : RESP_OKAY, i == 3});
        send_ar(4'd7, 32'h38, 8'd3, 3'd2, BURST_WRAP);
        for (int i = 0; i < 4; i++) begin
            serve(32'hB000_0000 + 32'(i), i == 2, (i == 0) ? 4 : 0);
            collect_r(0);
        end

        // Simultaneous AR/AW: read wins first
        obi_exp.push_back('{32'h300, 1'b0, 4'hF, 32'h0});
        r_exp.push_back('{32'h3333_3333, 4'd1, RESP_OKAY, 1'b1});
        obi_exp.push_back('{32'h80, 1'b1, 4'hF, 32'h5555_5555});
        b_exp.push_back('{4'd2, RESP_OKAY});
        req.ar.id = 4'd1; req.ar.addr = 32'h300; req.ar.len = 8'd0; req.ar.size = 3'd2; req.ar.burst = BURST_INCR;
        req.aw.id = 4'd2; req.aw.addr = 32'h80;  req.aw.len = 8'd0; req.aw.size = 3'd2; req.aw.burst = BURST_INCR;
        req.ar_valid = 1'b1; req.aw_valid = 1'b1;
        #1;
        chk("tie1_ar_ready", resp.ar_ready, 1);
        chk("tie1_aw_ready", resp.aw_ready, 0);
        tick();
        req.ar_valid = 1'b0;
        serve(32'h3333_3333, 1'b0, 0);
        collect_r(0);
        send_aw(4'd2, 32'h80, 8'd0, 3'd2, BURST_INCR);
        send_w(32'h5555_5555, 4'hF, 1'b1);
        serve(32'h0, 1'b0, 0);
        collect_b(0);

        // Simultaneous again: write wins this time
        obi_exp.push_back('{32'h84, 1'b1, 4'h1, 32'h6666_6666});
        b_exp.push_back('{4'd4, RESP_OKAY});
        obi_exp.push_back('{32'h304, 1'b0, 4'hF, 32'h0});
        r_exp.push_back('{32'h7777_7777, 4'd6, RESP_OKAY, 1'b1});
        req.ar.id = 4'd6; req.ar.addr = 32'h304;
        req.aw.id = 4'd4; req.aw.addr = 32'h84;
        req.ar_valid = 1'b1; req.aw_valid = 1'b1;
        #1;
        chk("tie2_aw_ready", resp.aw_ready, 1);
        chk("tie2_ar_ready", resp.ar_ready, 0);
        tick();
        req.aw_valid = 1'b0;
        send_w(32'h6666_6666, 4'h1, 1'b1);
        serve(32'h0, 1'b0, 0);
        collect_b(0);
        send_ar(4'd6, 32'h304, 8'd0, 3'd2, BURST_INCR);
        serve(32'h7777_7777, 1'b0, 0);
        collect_r(0);

        // Reset in the middle of a read burst
        obi_exp.push_back('{32'h500, 1'b0, 4'hF, 32'h0});
        r_exp.push_back('{32'h5050_5050, 4'd4, RESP_OKAY, 1'b0});
        send_ar(4'd4, 32'h500, 8'd3, 3'd2, BURST_INCR);
        serve(32'h5050_5050, 1'b0, 0);
        collect_r(0);
        chk("mid_burst_req", req_o, 1);
        arst_ni = 1'b0;
        #1;
        chk("arst_req", req_o, 0);
        chk("arst_r_valid", resp.r_valid, 0);
        chk("arst_b_valid", resp.b_valid, 0);
        chk("arst_state", dut.state_q, ST_IDLE);
        tick();
        arst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_req", req_o, 0);
            chk("post_rst_r_valid", resp.r_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
